// File: rtl/ds_decimator_pkg.sv
// Shared constants and types for the delta-sigma receive decimator.
// PCM width/limit match the ds_dac side of the link.
package ds_decimator_pkg;

  localparam int DS_PCM_W = 16;
  localparam logic [DS_PCM_W-1:0] DS_PCM_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    PR_NONE,
    PR_ONE,
    PR_DONE
  } prime_e;

endpackage

// File: rtl/ds_decimator_if.sv
// Bitstream-in / PCM-out bundle of the decimator.
// slave = decimator side, master = driver/consumer side.
interface ds_decimator_if
  import ds_decimator_pkg::*;
();

  logic                clk_en;
  logic                clr;
  logic                din;
  logic                ce_out;
  logic [DS_PCM_W-1:0] dout;
  logic                dout_valid;
  logic                clip;

  modport master (
    output clk_en, clr, din,
    input  ce_out, dout, dout_valid, clip
  );

  modport slave (
    input  clk_en, clr, din,
    output ce_out, dout, dout_valid, clip
  );

endinterface

// File: rtl/ds_cic_stage.sv
// One CIC section: modular integrator plus comb with a decimated delay.
// FWD exposes the post-update integrator value instead of the stored one.
module ds_cic_stage #(
  parameter int W   = 17,
  parameter bit FWD = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         dump,
  input  logic [W-1:0] int_in,
  output logic [W-1:0] int_out,
  input  logic [W-1:0] comb_in,
  output logic [W-1:0] comb_out
);

  logic [W-1:0] acc;
  logic [W-1:0] acc_nxt;
  logic [W-1:0] z;

  assign acc_nxt  = acc + int_in;
  assign int_out  = FWD ? acc_nxt : acc;
  assign comb_out = comb_in - z;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      z   <= '0;
    end else if (clr) begin
      acc <= '0;
      z   <= '0;
    end else if (en) begin
      acc <= acc_nxt;
      if (dump) z <= comb_in;
    end
  end

endmodule

// File: rtl/ds_decimator.sv
// sinc^2 decimator: 1-bit bitstream in, saturated 16-bit PCM out.
// Two CIC sections, decimation phase, priming FSM and output register.
module ds_decimator
  import ds_decimator_pkg::*;
#(
  parameter int LOG2_DECIM = 8
) (
  input logic          clk,
  input logic          rst,
  ds_decimator_if.slave bus
);

  localparam int W  = 2*LOG2_DECIM + 1;
  localparam int SH = 2*LOG2_DECIM;

  logic [LOG2_DECIM-1:0]   phase;
  logic                    tick;
  logic                    primed;
  logic [W-1:0]            din_w;
  logic [W-1:0]            i1;
  logic [W-1:0]            i2_nxt;
  logic [W-1:0]            c1;
  logic [W-1:0]            c2;
  logic                    tick_q;
  logic [W-1:0]            y_q;
  logic [W+DS_PCM_W-1:0]   wide;
  logic                    sat;
  logic [DS_PCM_W-1:0]     pcm;
  prime_e                  prime_q;
  prime_e                  prime_d;

  assign bus.ce_out = bus.clk_en;
  assign tick       = bus.clk_en && (phase == '1);
  assign din_w      = {{(W-1){1'b0}}, bus.din};

  ds_cic_stage #(.W(W), .FWD(1'b0)) u_s1 (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.clr),
    .en       (bus.clk_en),
    .dump     (tick),
    .int_in   (din_w),
    .int_out  (i1),
    .comb_in  (i2_nxt),
    .comb_out (c1)
  );

  ds_cic_stage #(.W(W), .FWD(1'b1)) u_s2 (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.clr),
    .en       (bus.clk_en),
    .dump     (tick),
    .int_in   (i1),
    .int_out  (i2_nxt),
    .comb_in  (c1),
    .comb_out (c2)
  );

  // Shift by 16 then by 2*LOG2_DECIM covers both scale directions.
  assign wide = {y_q, {DS_PCM_W{1'b0}}} >> SH;
  assign sat  = |wide[W+DS_PCM_W-1:DS_PCM_W];
  assign pcm  = sat ? DS_PCM_MAX : wide[DS_PCM_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prime_q <= PR_NONE;
    else     prime_q <= prime_d;
  end

  always_comb begin
    prime_d = prime_q;
    if (bus.clr) begin
      prime_d = PR_NONE;
    end else if (tick) begin
      unique case (prime_q)
        PR_NONE: prime_d = PR_ONE;
        PR_ONE:  prime_d = PR_DONE;
        default: prime_d = PR_DONE;
      endcase
    end
  end

  assign primed = (prime_q == PR_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase          <= '0;
      tick_q         <= 1'b0;
      y_q            <= '0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.clip       <= 1'b0;
    end else if (bus.clr) begin
      phase          <= '0;
      tick_q         <= 1'b0;
      y_q            <= '0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.clip       <= 1'b0;
    end else begin
      if (bus.clk_en) phase <= phase + LOG2_DECIM'(1);
      tick_q         <= tick && primed;
      if (tick) y_q  <= c2;
      bus.dout_valid <= tick_q;
      if (tick_q) begin
        bus.dout <= pcm;
        bus.clip <= sat;
      end
    end
  end

endmodule

// File: tb/tb_ds_decimator.sv
// Bench for ds_decimator: LOG2_DECIM=8 and 4 side by side, same stimulus.
// Direct-convolution sinc^2 reference plus literal spot checks.
module tb_ds_decimator;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic clr    = 1'b0;
  logic clk_en = 1'b0;
  logic din    = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  ds_decimator_if b8 ();
  ds_decimator_if b4 ();

  assign b8.clk_en = clk_en;
  assign b8.clr    = clr;
  assign b8.din    = din;
  assign b4.clk_en = clk_en;
  assign b4.clr    = clr;
  assign b4.din    = din;

  ds_decimator #(.LOG2_DECIM(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8.slave)
  );

  ds_decimator #(.LOG2_DECIM(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4.slave)
  );

  always #5 clk = ~clk;

  function automatic int nval(input int u);
    return (u == 0) ? 256 : 16;
  endfunction

  // sinc^2 response with a one-sample delay: newest bit weight 0,
  // weights rise 1..N then fall back to 1 over the last 2N bits.
  function automatic int sinc2(input bit q[$], input int n);
    int acc;
    int sz;
    acc = 0;
    sz  = q.size();
    for (int i = 1; i < 2*n; i++) begin
      if (i < sz && q[sz-1-i]) acc += (i <= n) ? i : 2*n - i;
    end
    return acc;
  endfunction

  function automatic longint scaled(input int y, input int n);
    return (longint'(y) * 65536) / longint'(n * n);
  endfunction

  bit     hist [2][$];
  int     scnt   [2];
  int     ticks  [2];
  bit     m_pend [2];
  int     m_pd   [2];
  bit     m_pc   [2];
  bit     m_valid[2];
  int     m_dout [2];
  bit     m_clip [2];

  function automatic void m_clear(input int u);
    hist[u].delete();
    scnt[u]    = 0;
    ticks[u]   = 0;
    m_pend[u]  = 1'b0;
    m_pd[u]    = 0;
    m_pc[u]    = 1'b0;
    m_valid[u] = 1'b0;
    m_dout[u]  = 0;
    m_clip[u]  = 1'b0;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        m_clear(u);
      end else begin
        longint s;
        m_valid[u] = m_pend[u];
        if (m_pend[u]) begin
          m_dout[u] = m_pd[u];
          m_clip[u] = m_pc[u];
        end
        m_pend[u] = 1'b0;
        if (clr) begin
          m_clear(u);
        end else if (clk_en) begin
          hist[u].push_back(din);
          if (hist[u].size() > 2*nval(u)) void'(hist[u].pop_front());
          scnt[u]++;
          if (scnt[u] == nval(u)) begin
            scnt[u] = 0;
            ticks[u]++;
            if (ticks[u] >= 3) begin
              s         = scaled(sinc2(hist[u], nval(u)), nval(u));
              m_pc[u]   = (s > 65535);
              m_pd[u]   = m_pc[u] ? 65535 : int'(s);
              m_pend[u] = 1'b1;
            end
          end
        end
      end
    end
  end

  logic [15:0] a_dout[2];
  logic        a_v   [2];
  logic        a_c   [2];
  logic        a_ce  [2];

  assign a_dout[0] = b8.dout;
  assign a_dout[1] = b4.dout;
  assign a_v[0]    = b8.dout_valid;
  assign a_v[1]    = b4.dout_valid;
  assign a_c[0]    = b8.clip;
  assign a_c[1]    = b4.clip;
  assign a_ce[0]   = b8.ce_out;
  assign a_ce[1]   = b4.ce_out;

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      n_chk++;
      if (a_ce[u] !== clk_en) begin
        n_fail++;
        $display("FAIL ce_out[%0d] t=%0t: got %b expected %b",
                 u, $time, a_ce[u], clk_en);
      end
      n_chk++;
      if (a_v[u] !== m_valid[u] || a_dout[u] !== 16'(m_dout[u]) ||
          a_c[u] !== m_clip[u]) begin
        n_fail++;
        $display("FAIL model[%0d] t=%0t: got v=%b d=%0d c=%b expected v=%b d=%0d c=%b",
                 u, $time, a_v[u], a_dout[u], a_c[u],
                 m_valid[u], m_dout[u], m_clip[u]);
      end
    end
  end

  int cnt;
  int vt8[$];
  int vt4[$];
  int ld8;
  int ld4;
  bit lc8;
  bit lc4;

  always @(posedge clk or posedge rst) begin
    if (rst) cnt <= 0;
    else     cnt <= cnt + 1;
  end

  always @(negedge clk) begin
    if (b8.dout_valid === 1'b1) begin
      vt8.push_back(cnt);
      ld8 = int'(b8.dout);
      lc8 = b8.clip;
    end
    if (b4.dout_valid === 1'b1) begin
      vt4.push_back(cnt);
      ld4 = int'(b4.dout);
      lc4 = b4.clip;
    end
  end

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run(input int ncyc, input bit [7:0] pat,
                     input int plen, input bit half);
    int s;
    s = 0;
    for (int k = 0; k < ncyc; k++) begin
      clk_en = !half || (k % 2 == 0);
      din    = pat[s % plen];
      if (clk_en) s++;
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_clr();
    clr    = 1'b1;
    clk_en = 1'b0;
    @(posedge clk);
    #2;
    clr = 1'b0;
  endtask

  typedef struct {
    bit [7:0] pat;
    int       plen;
    int       e8;
    int       e4;
  } pat_t;

  pat_t tbl[3];
  int   base;

  initial begin
    tbl[0] = '{pat: 8'h00, plen: 1, e8: 0,     e4: 0};
    tbl[1] = '{pat: 8'h01, plen: 2, e8: 32768, e4: 32768};
    tbl[2] = '{pat: 8'h01, plen: 4, e8: 16384, e4: 16384};

    repeat (3) @(posedge clk);
    #2;
    chk("rst_dout8",  b8.dout, 0);
    chk("rst_valid8", b8.dout_valid, 0);
    chk("rst_clip8",  b8.clip, 0);
    chk("rst_dout4",  b4.dout, 0);

    rst = 1'b0;
    vt8.delete();
    vt4.delete();
    run(1100, 8'h01, 1, 1'b0);
    chk("ones_first8",  qget(vt8, 0), 769);
    chk("ones_second8", qget(vt8, 1), 1025);
    chk("ones_dout8",   ld8, 65535);
    chk("ones_clip8",   lc8, 1);
    chk("ones_first4",  qget(vt4, 0), 49);
    chk("ones_second4", qget(vt4, 1), 65);
    chk("ones_dout4",   ld4, 65535);
    chk("ones_clip4",   lc4, 1);

    for (int i = 0; i < 3; i++) begin
      pulse_clr();
      ld8 = -1;
      ld4 = -1;
      run(1100, tbl[i].pat, tbl[i].plen, 1'b0);
      chk($sformatf("pat%0d_dout8", i), ld8, tbl[i].e8);
      chk($sformatf("pat%0d_clip8", i), lc8, 0);
      chk($sformatf("pat%0d_dout4", i), ld4, tbl[i].e4);
      chk($sformatf("pat%0d_clip4", i), lc4, 0);
    end

    pulse_clr();
    vt8.delete();
    vt4.delete();
    run(2200, 8'h01, 1, 1'b1);
    chk("half_period8", qget(vt8, 1) - qget(vt8, 0), 512);
    chk("half_dout8",   ld8, 65535);
    chk("half_period4", qget(vt4, 1) - qget(vt4, 0), 32);

    pulse_clr();
    run(100, 8'h01, 1, 1'b0);
    pulse_clr();
    base = cnt;
    vt8.delete();
    vt4.delete();
    run(800, 8'h01, 1, 1'b0);
    chk("clr_first8", qget(vt8, 0) - base, 769);
    chk("clr_first4", qget(vt4, 0) - base, 49);

    run(50, 8'h01, 1, 1'b0);
    rst = 1'b1;
    #1;
    chk("arst_dout8",  b8.dout, 0);
    chk("arst_valid8", b8.dout_valid, 0);
    chk("arst_clip8",  b8.clip, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    vt8.delete();
    vt4.delete();
    run(800, 8'h01, 1, 1'b0);
    chk("arst_first8", qget(vt8, 0), 769);
    chk("arst_first4", qget(vt4, 0), 49);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
